// File: rtl/wisc_cache_pkg.sv
// Shared definitions for the WISC-FA24 L1 cache miss-fill controllers.
package wisc_cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   localparam int unsigned DEF_BLOCK_WORDS = 8;
   localparam int unsigned DEF_MEM_LATENCY = 4;
   localparam int unsigned OFFSET_W        = $clog2(DEF_BLOCK_WORDS) + 1;

   // Byte-offset width of a block of 'words' 16-bit words.
   function automatic int unsigned offset_width(input int unsigned words);
      return $clog2(words) + 1;
   endfunction

endpackage

// File: rtl/word_counter.sv
// Up-counter with synchronous clear (priority over increment) and async reset.
module word_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// L1 cache miss handler: stalls the pipeline, reads one block word per cycle
// from memory, steers returned words into the data array, then writes the tag.
module cache_fill_fsm
   import wisc_cache_pkg::*;
#(
   parameter int unsigned AWIDTH      = 16,
   parameter int unsigned DWIDTH      = 16,
   parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           miss_detected,
   input  logic [AWIDTH-1:0]              miss_address,
   output logic                           fsm_busy,
   output logic                           mem_en,
   output logic [AWIDTH-1:0]              mem_addr,
   input  logic                           mem_data_valid,
   output logic                           write_data_array,
   output logic [$clog2(BLOCK_WORDS)-1:0] data_word_idx,
   output logic                           write_tag_array
);

   localparam int unsigned LOG2W = $clog2(BLOCK_WORDS);
   localparam int unsigned OFF_W = offset_width(BLOCK_WORDS);
   localparam int unsigned TAG_W = AWIDTH - OFF_W;

   if (BLOCK_WORDS < 2 || BLOCK_WORDS > 64 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 ||
       DWIDTH == 0 || MEM_LATENCY == 0 || AWIDTH <= OFF_W) begin : g_param_check
      $error("cache_fill_fsm: illegal parameter set");
   end

   fill_state_e      state_q, state_d;
   logic [TAG_W-1:0] base_q, base_d;
   logic [LOG2W:0]   req_cnt;
   logic [LOG2W-1:0] rcv_cnt;
   logic             cnt_clr;
   logic             req_inc;
   logic             rcv_inc;
   logic             req_pending;
   logic             last_word;

   // Only the block-base bits of the miss address are kept.
   logic unused_offset_bits;
   assign unused_offset_bits = ^miss_address[OFF_W-1:0];

   word_counter #(.WIDTH(LOG2W + 1)) u_req_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (req_inc),
      .count (req_cnt)
   );

   word_counter #(.WIDTH(LOG2W)) u_rcv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (rcv_inc),
      .count (rcv_cnt)
   );

   assign req_pending = (req_cnt < (LOG2W + 1)'(BLOCK_WORDS));
   assign last_word   = (rcv_cnt == LOG2W'(BLOCK_WORDS - 1));

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      fsm_busy         = 1'b0;
      mem_en           = 1'b0;
      mem_addr         = '0;
      write_data_array = 1'b0;
      data_word_idx    = '0;
      write_tag_array  = 1'b0;
      cnt_clr          = 1'b0;
      req_inc          = 1'b0;
      rcv_inc          = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Stall in the miss cycle itself, but never while reset is held.
            fsm_busy = miss_detected && !rst;
            if (miss_detected) begin
               base_d  = miss_address[AWIDTH-1:OFF_W];
               cnt_clr = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            fsm_busy = 1'b1;
            mem_en   = req_pending;
            req_inc  = req_pending;
            if (req_pending) begin
               // Field concatenation: the word offset can never carry into the tag.
               mem_addr = {base_q, req_cnt[LOG2W-1:0], 1'b0};
            end
            write_data_array = mem_data_valid;
            data_word_idx    = rcv_cnt;
            rcv_inc          = mem_data_valid;
            if (mem_data_valid && last_word) begin
               write_tag_array = 1'b1;
               state_d         = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a fixed-latency, optionally gappy memory model.
module tb_cache_fill_fsm;

   localparam int AW  = 16;
   localparam int BW  = 8;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          miss_detected;
   logic [AW-1:0] miss_address;
   logic          fsm_busy;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic          mem_data_valid;
   logic          write_data_array;
   logic [2:0]    data_word_idx;
   logic          write_tag_array;

   logic mdv_model   = 1'b0;
   logic stray_valid = 1'b0;
   logic gap_mode    = 1'b0;
   assign mem_data_valid = mdv_model | stray_valid;

   cache_fill_fsm #(
      .AWIDTH      (AW),
      .DWIDTH      (16),
      .BLOCK_WORDS (BW),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .fsm_busy         (fsm_busy),
      .mem_en           (mem_en),
      .mem_addr         (mem_addr),
      .mem_data_valid   (mem_data_valid),
      .write_data_array (write_data_array),
      .data_word_idx    (data_word_idx),
      .write_tag_array  (write_tag_array)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard queues, filled when a miss is driven.
   logic [AW-1:0] exp_addr[$];
   int            exp_idx[$];
   int            exp_tag[$];

   task automatic push_fill(input logic [AW-1:0] addr);
      logic [AW-1:0] base;
      base = addr & 16'hFFF0;
      for (int i = 0; i < BW; i++) begin
         exp_addr.push_back(base + 16'(2 * i));
         exp_idx.push_back(i);
      end
      exp_tag.push_back(1);
   endtask

   // Memory model: each request returns LAT cycles later, or later still in gap mode.
   int pending[$];
   always @(negedge clk) if (mem_en) pending.push_back(cyc + LAT);

   always @(posedge clk) begin
      #1;
      if (pending.size() > 0 && pending[0] <= cyc && !(gap_mode && $urandom_range(0, 2) == 0)) begin
         mdv_model = 1'b1;
         void'(pending.pop_front());
      end else begin
         mdv_model = 1'b0;
      end
   end

   int   tag_cnt       = 0;
   int   tag_cyc       = 0;
   int   wr_cnt        = 0;
   int   req_start_cyc = 0;
   logic prev_en       = 1'b0;

   always @(negedge clk) begin
      if (mem_en) begin
         if (!prev_en) req_start_cyc = cyc;
         if (exp_addr.size() == 0) check_eq("unexp_req", 1, 0);
         else check_eq("mem_addr", mem_addr, exp_addr.pop_front());
      end else begin
         check_eq("addr_idle_zero", mem_addr, 0);
      end
      prev_en = mem_en;
      if (write_data_array) begin
         wr_cnt++;
         check_eq("write_needs_valid", mem_data_valid, 1);
         if (exp_idx.size() == 0) check_eq("unexp_write", 1, 0);
         else check_eq("data_word_idx", data_word_idx, exp_idx.pop_front());
      end
      if (write_tag_array) begin
         tag_cnt++;
         tag_cyc = cyc;
         check_eq("tag_on_last_idx", data_word_idx, BW - 1);
         check_eq("tag_with_write", write_data_array, 1);
         if (exp_tag.size() == 0) check_eq("unexp_tag", 1, 0);
         else void'(exp_tag.pop_front());
      end
   end

   task automatic check_zero(input string tag);
      check_eq({tag, "_busy"}, fsm_busy, 0);
      check_eq({tag, "_mem_en"}, mem_en, 0);
      check_eq({tag, "_mem_addr"}, mem_addr, 0);
      check_eq({tag, "_wda"}, write_data_array, 0);
      check_eq({tag, "_idx"}, data_word_idx, 0);
      check_eq({tag, "_wta"}, write_tag_array, 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_miss(input logic [AW-1:0] addr, output int t);
      miss_detected = 1'b1;
      miss_address  = addr;
      t             = cyc;
      push_fill(addr);
      @(negedge clk);
      #1;
      check_eq("busy_miss_cycle", fsm_busy, 1);
      next_cycle();
   endtask

   task automatic wait_tag(input int limit);
      int start;
      int n;
      start = tag_cnt;
      n     = 0;
      while (tag_cnt == start && n < limit) begin
         @(negedge clk);
         #1;
         check_eq("busy_during_fill", fsm_busy, 1);
         n++;
      end
      if (tag_cnt == start) check_eq("tag_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t;
      int t1;
      int wr0;
      int tg0;
      int n;

      rst           = 1'b1;
      miss_detected = 1'b0;
      miss_address  = '0;
      @(negedge clk);
      #1;
      check_zero("reset");
      next_cycle();
      rst = 1'b0;

      // Idle with stray memory returns and no miss.
      for (int i = 0; i < 6; i++) begin
         stray_valid = (i % 2 == 0);
         @(negedge clk);
         #1;
         check_zero("idle_stray");
         next_cycle();
      end
      stray_valid = 1'b0;
      check_eq("idle_no_writes", wr_cnt, 0);

      // Basic fill at 0x1236 with exact timing.
      wr0 = wr_cnt;
      start_miss(16'h1236, t);
      wait_tag(40);
      check_eq("first_req_T1", req_start_cyc - t, 1);
      check_eq("tag_at_T12", tag_cyc - t, 12);
      check_eq("basic_writes", wr_cnt - wr0, 8);
      next_cycle();
      miss_detected = 1'b0;
      @(negedge clk);
      #1;
      check_eq("busy_low_T13", fsm_busy, 0);
      check_eq("busy_low_cycle", cyc - t, 13);
      next_cycle();

      // Top-of-memory block must not wrap.
      wr0 = wr_cnt;
      start_miss(16'hFFFE, t);
      wait_tag(40);
      check_eq("top_writes", wr_cnt - wr0, 8);
      check_eq("top_tag_T12", tag_cyc - t, 12);
      next_cycle();
      miss_detected = 1'b0;
      next_cycle();

      // Gappy returns with the miss dropped mid-fill.
      gap_mode = 1'b1;
      wr0      = wr_cnt;
      tg0      = tag_cnt;
      start_miss(16'h5A5A, t);
      repeat (2) next_cycle();
      miss_detected = 1'b0;
      wait_tag(200);
      check_eq("gap_writes", wr_cnt - wr0, 8);
      check_eq("gap_one_tag", tag_cnt - tg0, 1);
      gap_mode = 1'b0;
      next_cycle();
      @(negedge clk);
      #1;
      check_eq("gap_busy_low", fsm_busy, 0);
      next_cycle();

      // Reset after the third returned word.
      wr0 = wr_cnt;
      tg0 = tag_cnt;
      start_miss(16'h0A00, t);
      n = 0;
      while (wr_cnt - wr0 < 3 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (wr_cnt - wr0 < 3) check_eq("rst_wait_timeout", 0, 1);
      next_cycle();
      rst           = 1'b1;
      miss_detected = 1'b0;
      exp_addr.delete();
      exp_idx.delete();
      exp_tag.delete();
      @(negedge clk);
      #1;
      check_zero("rst_mid");
      next_cycle();
      rst = 1'b0;
      n   = 0;
      while (pending.size() > 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("rst_drain", pending.size(), 0);
      @(negedge clk);
      #1;
      check_zero("rst_late_returns");
      check_eq("rst_no_tag", tag_cnt - tg0, 0);
      check_eq("rst_writes", wr_cnt - wr0, 3);
      next_cycle();
      wr0 = wr_cnt;
      start_miss(16'h0040, t);
      wait_tag(40);
      check_eq("refill_writes", wr_cnt - wr0, 8);
      check_eq("refill_tag_T12", tag_cyc - t, 12);
      next_cycle();
      miss_detected = 1'b0;
      next_cycle();

      // Back-to-back misses: second miss presented in the tag-write cycle.
      tg0 = tag_cnt;
      start_miss(16'h0100, t);
      repeat (11) next_cycle();
      miss_address = 16'h2200;
      push_fill(16'h2200);
      @(negedge clk);
      #1;
      check_eq("b2b_first_tag", tag_cnt - tg0, 1);
      t1 = tag_cyc;
      check_eq("b2b_first_tag_T12", t1 - t, 12);
      next_cycle();
      @(negedge clk);
      #1;
      check_eq("b2b_idle_busy", fsm_busy, 1);
      wait_tag(40);
      check_eq("b2b_req_gap", req_start_cyc - t1, 2);
      check_eq("b2b_second_tag", tag_cnt - tg0, 2);
      next_cycle();
      miss_detected = 1'b0;
      @(negedge clk);
      #1;
      check_eq("b2b_busy_low", fsm_busy, 0);

      check_eq("sb_addr_left", exp_addr.size(), 0);
      check_eq("sb_idx_left", exp_idx.size(), 0);
      check_eq("sb_tag_left", exp_tag.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
